// File: rtl/audio_pkg.sv
// Shared audio types and constants for the Pocket audio path.
package audio_pkg;

  localparam int AUDIO_FS_HZ = 48000;

  typedef struct packed {
    logic signed [15:0] left;
    logic signed [15:0] right;
  } stereo_sample_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/i2s_bit_timer.sv
// I2S frame timing: free-running frame counter, registered sclk/lrck, slot and strobes.
// sclk/lrck lag the counter by one clk so they move together with the serial data register.
module i2s_bit_timer #(
  parameter int SCLK_DIV  = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         sclk,
  output logic                         lrck,
  output logic [$clog2(SLOT_BITS)-1:0] slot,
  output logic                         channel,
  output logic                         phase0,
  output logic                         frame_start
);

  localparam int PW = $clog2(SCLK_DIV);
  localparam int SW = $clog2(SLOT_BITS);
  localparam int CW = PW + SW + 1;

  logic [CW-1:0] cnt;
  logic [PW-1:0] phase;

  assign phase       = cnt[PW-1:0];
  assign slot        = cnt[PW+SW-1:PW];
  assign channel     = cnt[CW-1];
  assign phase0      = (phase == '0);
  assign frame_start = (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      sclk <= 1'b0;
      lrck <= 1'b0;
    end else begin
      cnt  <= cnt + CW'(1);
      // SCLK_DIV is a power of 2, so phase >= SCLK_DIV/2 is the top phase bit
      sclk <= phase[PW-1];
      if (phase0) lrck <= channel;
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter with a one-pair hold buffer; left MSB appears SCLK_DIV clk after frame_start.
// sample_ready is low while the hold register is full; AUDIO_I2S_UNDERRUN_COUNT_EN enables underrun_count.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH  = 16,
  parameter int SLOT_BITS     = 32,
  parameter int SCLK_DIV      = 4,
  parameter int UNDERRUN_HOLD = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_left,
  input  logic [SAMPLE_WIDTH-1:0] sample_right,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic                    mute,
  output logic                    audio_mclk,
  output logic                    audio_sclk,
  output logic                    audio_lrck,
  output logic                    audio_dac,
  output logic [15:0]             underrun_count
);

  localparam int SW = $clog2(SLOT_BITS);

  logic [SW-1:0]           slot;
  logic                    channel;
  logic                    phase0;
  logic                    frame_start;

  logic [SAMPLE_WIDTH-1:0] hold_l, hold_r;
  logic [SAMPLE_WIDTH-1:0] act_l, act_r;
  logic [SAMPLE_WIDTH-1:0] cur_word;
  logic [SAMPLE_WIDTH-1:0] shreg;
  logic                    hold_full;
  logic                    hold_full_nxt;
  logic                    accept;

  i2s_bit_timer #(
    .SCLK_DIV  (SCLK_DIV),
    .SLOT_BITS (SLOT_BITS)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .sclk        (audio_sclk),
    .lrck        (audio_lrck),
    .slot        (slot),
    .channel     (channel),
    .phase0      (phase0),
    .frame_start (frame_start)
  );

  assign audio_mclk = clk;
  assign accept     = sample_valid && sample_ready;
  assign cur_word   = channel ? act_r : act_l;

  always_comb begin
    hold_full_nxt = hold_full;
    if (frame_start && hold_full) hold_full_nxt = 1'b0;
    if (accept)                   hold_full_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_l       <= '0;
      hold_r       <= '0;
      act_l        <= '0;
      act_r        <= '0;
      shreg        <= '0;
      hold_full    <= 1'b0;
      sample_ready <= 1'b0;
      audio_dac    <= 1'b0;
    end else begin
      if (accept) begin
        hold_l <= sample_left;
        hold_r <= sample_right;
      end
      // a pair landing in hold on frame_start itself waits for the next frame
      if (frame_start) begin
        if (hold_full) begin
          act_l <= hold_l;
          act_r <= hold_r;
        end else if (UNDERRUN_HOLD == 0) begin
          act_l <= '0;
          act_r <= '0;
        end
      end
      hold_full    <= hold_full_nxt;
      sample_ready <= !hold_full_nxt;
      // slot 1 loads after frame_start has refreshed active; zeros shift in past the word
      if (phase0) begin
        if (slot == '0) begin
          audio_dac <= 1'b0;
          shreg     <= '0;
        end else if (slot == SW'(1)) begin
          audio_dac <= cur_word[SAMPLE_WIDTH-1] & ~mute;
          shreg     <= cur_word << 1;
        end else begin
          audio_dac <= shreg[SAMPLE_WIDTH-1] & ~mute;
          shreg     <= shreg << 1;
        end
      end
    end
  end

`ifdef AUDIO_I2S_UNDERRUN_COUNT_EN
  logic [15:0] underrun_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_cnt <= '0;
    end else if (frame_start && !hold_full) begin
      underrun_cnt <= sat_inc16(underrun_cnt);
    end
  end

  assign underrun_count = underrun_cnt;
`else
  assign underrun_count = 16'd0;
`endif

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: two instances (repeat-on-underrun and zero-on-underrun) share stimulus.
module tb_audio_i2s_tx;
  import audio_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic        mute = 1'b0;
  logic [15:0] sample_left = '0;
  logic [15:0] sample_right = '0;

  logic        rdy  [2];
  logic        mclk [2];
  logic        sclk [2];
  logic        lrck [2];
  logic        dac  [2];
  logic [15:0] ucnt [2];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  localparam stereo_sample_t Z  = '0;
  localparam stereo_sample_t A  = '{left: 16'hA55A, right: 16'h8001};
  localparam stereo_sample_t P0 = '{left: 16'h0001, right: 16'h8000};
  localparam stereo_sample_t P1 = '{left: 16'h7FFF, right: 16'hFFFF};
  localparam stereo_sample_t P2 = '{left: 16'h3C3C, right: 16'hC3C3};
  localparam stereo_sample_t P3 = '{left: 16'hFFFF, right: 16'h0000};
  localparam stereo_sample_t P4 = '{left: 16'h1234, right: 16'h00FF};
  localparam stereo_sample_t P5 = '{left: 16'hDEAD, right: 16'hBEEF};

  typedef struct {
    int             frame;
    stereo_sample_t h;
    stereo_sample_t z;
  } exp_t;

  exp_t q[$];

  audio_i2s_tx #(.UNDERRUN_HOLD(1)) u_hold (
    .clk(clk), .reset(reset), .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .sample_ready(rdy[0]), .mute(mute),
    .audio_mclk(mclk[0]), .audio_sclk(sclk[0]), .audio_lrck(lrck[0]),
    .audio_dac(dac[0]), .underrun_count(ucnt[0])
  );

  audio_i2s_tx #(.UNDERRUN_HOLD(0)) u_zero (
    .clk(clk), .reset(reset), .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .sample_ready(rdy[1]), .mute(mute),
    .audio_mclk(mclk[1]), .audio_sclk(sclk[1]), .audio_lrck(lrck[1]),
    .audio_dac(dac[1]), .underrun_count(ucnt[1])
  );

  always #5 clk = ~clk;

  // at a negedge, cyc equals the index of the next posedge since reset release
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wexp(logic [15:0] s);
    return {1'b0, s, 15'b0};
  endfunction

  task automatic pushx(int f, stereo_sample_t h, stereo_sample_t z);
    exp_t e;
    e.frame = f;
    e.h     = h;
    e.z     = z;
    q.push_back(e);
  endtask

  task automatic chk_uc(int n);
    logic [15:0] e;
`ifdef AUDIO_I2S_UNDERRUN_COUNT_EN
    e = 16'(n);
`else
    e = 16'd0;
`endif
    chk($sformatf("underrun_count@%0d", cyc), {32'd0, ucnt[0], ucnt[1]}, {32'd0, e, e});
  endtask

  task automatic wait_edge(int e);
    while (cyc < e) @(negedge clk);
  endtask

  // presents p with valid high until accepted; returns the accepting edge index
  task automatic send(stereo_sample_t p, output int acc);
    sample_left  = p.left;
    sample_right = p.right;
    sample_valid = 1'b1;
    acc = -1;
    for (int n = 0; n < 700; n++) begin
      if (rdy[0] && rdy[1]) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      total++;
      bad++;
      $display("FAIL send_timeout: ready stayed 0 for 700 clk, want 1");
    end else begin
      @(negedge clk);
    end
  endtask

  // monitor: deserialises each instance on sclk rising, closes a frame at the lrck 1->0 rise
  logic [31:0] wl [2], wr [2], cl [2], cr [2];
  int          nl [2], nr [2], cnl [2], cnr [2];
  logic        sq [2], lsq [2], lprev [2];
  int          srise [2], lrise [2];
  int          mon_frame;
  logic        done;
  exp_t        ce;

  always @(negedge clk) begin
    done = 1'b0;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        wl[i] = '0; wr[i] = '0; nl[i] = 0; nr[i] = 0;
        sq[i] = 1'b0; lsq[i] = 1'b0; lprev[i] = 1'b0;
        srise[i] = -1; lrise[i] = -1;
      end
      mon_frame = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (lrck[i] && !lprev[i]) begin
          if (lrise[i] >= 0)
            chk($sformatf("lrck_period%0d", i), 64'(cyc - lrise[i]), 64'(12288000 / AUDIO_FS_HZ));
          lrise[i] = cyc;
        end
        lprev[i] = lrck[i];
        if (sclk[i] && !sq[i]) begin
          if (srise[i] >= 0)
            chk($sformatf("sclk_period%0d", i), 64'(cyc - srise[i]), 64'd4);
          srise[i] = cyc;
          if (!lrck[i] && lsq[i]) begin
            done = 1'b1;
            cl[i] = wl[i]; cr[i] = wr[i]; cnl[i] = nl[i]; cnr[i] = nr[i];
            wl[i] = '0; wr[i] = '0; nl[i] = 0; nr[i] = 0;
          end
          if (lrck[i]) begin
            wr[i] = {wr[i][30:0], dac[i]};
            nr[i]++;
          end else begin
            wl[i] = {wl[i][30:0], dac[i]};
            nl[i]++;
          end
          lsq[i] = lrck[i];
        end
        sq[i] = sclk[i];
      end
      if (done) begin
        if (q.size() > 0 && q[0].frame < mon_frame) begin
          total++;
          bad++;
          $display("FAIL frame_missed: frame %0d never decoded, now at frame %0d", q[0].frame, mon_frame);
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].frame == mon_frame) begin
          ce = q.pop_front();
          chk($sformatf("frame%0d_hold", mon_frame), {cl[0], cr[0]}, {wexp(ce.h.left), wexp(ce.h.right)});
          chk($sformatf("frame%0d_zero", mon_frame), {cl[1], cr[1]}, {wexp(ce.z.left), wexp(ce.z.right)});
          chk($sformatf("frame%0d_bits", mon_frame),
              {16'(cnl[0]), 16'(cnr[0]), 16'(cnl[1]), 16'(cnr[1])},
              {16'd32, 16'd32, 16'd32, 16'd32});
        end
        mon_frame++;
      end
    end
  end

  initial begin
    int a;
    repeat (3) @(negedge clk);
    chk("in_reset", {55'd0, rdy[0], rdy[1], lrck[0], lrck[1], dac[0], dac[1], sclk[0], sclk[1], mclk[0]}, 64'd0);
    chk_uc(0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {62'd0, rdy[0], rdy[1]}, 64'd3);

    // idle frames, then one pair
    pushx(0, Z, Z); pushx(1, Z, Z); pushx(2, Z, Z);
    wait_edge(356);  chk_uc(2);
    wait_edge(562);
    pushx(3, A, A); pushx(4, A, Z); pushx(5, A, Z);
    send(A, a);
    sample_valid = 1'b0;
    wait_edge(868);  chk_uc(3);
    wait_edge(1340); chk_uc(5);

    // continuous valid: one pair per frame
    wait_edge(1380);
    pushx(6, P0, P0); pushx(7, P1, P1); pushx(8, P2, P2); pushx(9, P3, P3);
    pushx(10, P3, Z); pushx(11, P3, Z);
    send(P0, a);
    chk("ready_drop", {63'd0, rdy[0] | rdy[1]}, 64'd0);
    send(P1, a); chk("accept_edge_p1", 64'(a), 64'd1537);
    send(P2, a); chk("accept_edge_p2", 64'(a), 64'd1793);
    send(P3, a); chk("accept_edge_p3", 64'(a), 64'd2049);
    sample_valid = 1'b0;
    wait_edge(2364); chk_uc(5);

    // valid exactly on frame_start with hold empty
    wait_edge(2816);
    pushx(12, P4, P4);
    send(P4, a); chk("accept_edge_fs", 64'(a), 64'd2816);
    sample_valid = 1'b0;
    wait_edge(2876); chk_uc(7);

    // muted frame, then unmuted repeat
    pushx(13, Z, Z); pushx(14, P4, Z);
    wait_edge(3328); mute = 1'b1;
    wait_edge(3584); mute = 1'b0;
    wait_edge(3644); chk_uc(9);

    // reset during slot 9 of the right channel
    wait_edge(4006);
    chk("pre_reset", {61'd0, dac[0], lrck[0], rdy[0]}, 64'd7);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset", {56'd0, dac[0], dac[1], lrck[0], lrck[1], rdy[0], rdy[1], sclk[0], sclk[1]}, 64'd0);
    chk_uc(0);
    @(negedge clk);
    reset = 1'b0;
    pushx(0, Z, Z); pushx(1, P5, P5);
    send(P5, a); chk("accept_edge_after_reset", 64'(a), 64'd1);
    sample_valid = 1'b0;
    wait_edge(316); chk_uc(1);
    wait_edge(532);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
